// File: rtl/popcount_scheduler.sv
// popcount_scheduler: round-robin arbiter sharing one chunked ones-counter
// among several requesters, returning count and winner ID via valid/ready.
module popcount_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4,
  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH,
  localparam int CW         = $clog2(DATA_WIDTH) + 1,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [CW-1:0]                 resp_count,
  output logic [IW-1:0]                 resp_id,
  output logic                          busy
);

  localparam int PW = $clog2(CHUNK_WIDTH) + 1;
  localparam int KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]            r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_gid;
  logic [IW-1:0]         r_resp_id;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_acc;
  logic [CW-1:0]         r_resp_count;
  logic [KW-1:0]         r_idx;

  logic                  w_found;
  logic [IW-1:0]         w_gnt;
  logic [IW-1:0]         w_ptr_nxt;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_sel;
  logic [PW-1:0]         w_pc;
  logic [CW-1:0]         w_sum;
  logic                  w_last;

  // first valid requester at or above the pointer, wrapping around
  always_comb begin
    int j;
    w_found = 1'b0;
    w_gnt   = '0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_gnt   = IW'(j);
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_found && !rst;
  assign w_ptr_nxt = (w_gnt == IW'(NUM_REQ - 1)) ? '0 : w_gnt + IW'(1);
  assign w_sel     = req_data[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];

  // one-hot acceptance strobe for the granted requester
  always_comb begin
    w_ready = '0;
    if (w_accept) w_ready[w_gnt] = 1'b1;
  end

  // ones in the low chunk of the shift register
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      w_pc = w_pc + PW'(r_shift[i]);
    end
  end

  assign w_sum  = r_acc + CW'(w_pc);
  assign w_last = (r_idx == KW'(NUM_CHUNKS - 1));

  // arbitration, chunked counting and response hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gid        <= '0;
      r_resp_id    <= '0;
      r_shift      <= '0;
      r_acc        <= '0;
      r_resp_count <= '0;
      r_idx        <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= w_sel;
            r_acc   <= '0;
            r_idx   <= '0;
            r_gid   <= w_gnt;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          r_acc   <= w_sum;
          r_shift <= r_shift >> CHUNK_WIDTH;
          r_idx   <= r_idx + KW'(1);
          if (w_last) begin
            r_resp_count <= w_sum;
            r_resp_id    <= r_gid;
            r_idx        <= '0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_count = r_resp_count;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_popcount_scheduler.sv
// tb_popcount_scheduler: directed scenario tasks with hand-computed
// expectations for the round-robin popcount scheduler.
module tb_popcount_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_count;
  logic [1:0]  resp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  popcount_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_count (resp_count),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    req_valid  = '0;
    resp_ready = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  // drives one request and collects its response; lat = -1 on timeout
  task automatic do_txn(input int id, input logic [15:0] d,
                        output logic [4:0] cnt, output logic [1:0] rid,
                        output int lat);
    int n;
    n = 0;
    cnt = '0;
    rid = '0;
    req_data[id*16 +: 16] = d;
    req_valid[id] = 1'b1;
    #1;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (req_ready[id] !== 1'b1) begin
      req_valid[id] = 1'b0;
      lat = -1;
      return;
    end
    step();
    req_valid[id] = 1'b0;
    lat = 1;
    #1;
    while (resp_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    if (resp_valid !== 1'b1) begin
      lat = -1;
      return;
    end
    cnt = resp_count;
    rid = resp_id;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    req_data   = '0;
    step();
    step();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid_busy: got %b want 00", {resp_valid, busy});
    end
    checks++;
    if (resp_count !== 5'd0 || resp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_resp: got count=%0d id=%0d want 0 0",
               resp_count, resp_id);
    end
    checks++;
    if (dut.r_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d want 0", dut.r_ptr);
    end
    req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single;
    int bad;
    bad = 0;
    req_data[47:32] = 16'hFFFF;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    for (int c = 1; c <= 4; c++) begin
      if (busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 4'b0)
        bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_count_phase: bad cycles %0d want 0", bad);
    end
    checks++;
    if (resp_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_cycle5: got valid=%b busy=%b want 1 1",
               resp_valid, busy);
    end
    checks++;
    if (resp_count !== 5'd16 || resp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_resp: got count=%0d id=%0d want 16 2",
               resp_count, resp_id);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_count !== 5'd16) begin
      errors++;
      $display("FAIL single_after: got busy=%b valid=%b count=%0d want 0 0 16",
               busy, resp_valid, resp_count);
    end
  endtask

  task automatic test_values;
    logic [15:0] vec [3];
    int          exp [3];
    logic [4:0]  cnt;
    logic [1:0]  rid;
    int          lat;
    vec[0] = 16'h8001; exp[0] = 2;
    vec[1] = 16'h0000; exp[1] = 0;
    vec[2] = 16'h00F0; exp[2] = 4;
    for (int i = 0; i < 3; i++) begin
      do_txn(0, vec[i], cnt, rid, lat);
      checks++;
      if (int'(cnt) !== exp[i] || rid !== 2'd0) begin
        errors++;
        $display("FAIL value_%0d: got count=%0d id=%0d want %0d 0",
                 i, cnt, rid, exp[i]);
      end
      checks++;
      if (lat !== 5 || busy !== 1'b0) begin
        errors++;
        $display("FAIL value_lat_%0d: got lat=%0d busy=%b want 5 0",
                 i, lat, busy);
      end
    end
  endtask

  task automatic test_round_robin;
    int g[$];
    int rc[$];
    int ri[$];
    int viol;
    int ptr1;
    int eg[5];
    int v;
    eg[0] = 0; eg[1] = 1; eg[2] = 2; eg[3] = 3; eg[4] = 0;
    pulse_reset();
    req_data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    resp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    viol = 0;
    ptr1 = -1;
    for (int c = 0; c < 60 && g.size() < 5; c++) begin
      if (busy && req_ready !== 4'b0) viol++;
      if (resp_valid) begin
        ri.push_back(int'(resp_id));
        rc.push_back(int'(resp_count));
      end
      for (int k = 0; k < 4; k++) if (req_ready[k]) g.push_back(k);
      step();
      if (g.size() == 1 && ptr1 < 0) ptr1 = int'(dut.r_ptr);
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      if (busy && req_ready !== 4'b0) viol++;
      step();
    end
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = (g.size() > i) ? g[i] : -1;
      checks++;
      if (v !== eg[i]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %0d want %0d", i, v, eg[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ri.size() <= i || ri[i] !== i || rc[i] !== i + 1) begin
        errors++;
        $display("FAIL rr_resp_%0d: got n=%0d want id=%0d count=%0d",
                 i, ri.size(), i, i + 1);
      end
    end
    checks++;
    if (ptr1 !== 1) begin
      errors++;
      $display("FAIL rr_ptr_first: got %0d want 1", ptr1);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL rr_ready_busy: got %0d cycles want 0", viol);
    end
  endtask

  task automatic test_skip_wrap;
    logic [4:0] cnt;
    logic [1:0] rid;
    int         lat;
    int         g[$];
    int         ri[$];
    int         rc[$];
    logic [3:0] clr;
    do_txn(2, 16'h0101, cnt, rid, lat);
    checks++;
    if (dut.r_ptr !== 2'd3 || cnt !== 5'd2) begin
      errors++;
      $display("FAIL skip_setup: got ptr=%0d count=%0d want 3 2",
               dut.r_ptr, cnt);
    end
    do_txn(1, 16'h0003, cnt, rid, lat);
    checks++;
    if (rid !== 2'd1 || cnt !== 5'd2 || dut.r_ptr !== 2'd2) begin
      errors++;
      $display("FAIL skip_grant: got id=%0d count=%0d ptr=%0d want 1 2 2",
               rid, cnt, dut.r_ptr);
    end
    req_data[63:48] = 16'hF000;
    req_data[15:0]  = 16'h0001;
    req_valid = 4'b1001;
    resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 40 && ri.size() < 2; c++) begin
      if (resp_valid) begin
        ri.push_back(int'(resp_id));
        rc.push_back(int'(resp_count));
      end
      clr = req_ready;
      for (int k = 0; k < 4; k++) if (clr[k]) g.push_back(k);
      step();
      req_valid = req_valid & ~clr;
      #1;
    end
    resp_ready = 1'b0;
    req_valid = '0;
    checks++;
    if (g.size() < 2 || g[0] !== 3 || g[1] !== 0) begin
      errors++;
      $display("FAIL wrap_grants: got n=%0d first=%0d want 3 then 0",
               g.size(), (g.size() > 0) ? g[0] : -1);
    end
    checks++;
    if (ri.size() < 2 || ri[0] !== 3 || rc[0] !== 4 ||
        ri[1] !== 0 || rc[1] !== 1) begin
      errors++;
      $display("FAIL wrap_resps: got n=%0d want id3/4 then id0/1", ri.size());
    end
  endtask

  task automatic test_backpressure;
    int n;
    int bad_v;
    int bad_c;
    int bad_r;
    int extra;
    logic [3:0] first;
    req_data = {16'hFFFF, 16'h00FF, 16'h1234, 16'h0001};
    req_valid = 4'hF;
    resp_ready = 1'b0;
    #1;
    first = req_ready;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (first !== 4'b0010 || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant: got ready=%b valid=%b want 0010 1",
               first, resp_valid);
    end
    bad_v = 0;
    bad_c = 0;
    bad_r = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid !== 1'b1) bad_v++;
      if (resp_count !== 5'd5 || resp_id !== 2'd1) bad_c++;
      if (req_ready !== 4'b0) bad_r++;
      step();
    end
    checks++;
    if (bad_v !== 0) begin
      errors++;
      $display("FAIL bp_valid_hold: got %0d bad cycles want 0", bad_v);
    end
    checks++;
    if (bad_c !== 0) begin
      errors++;
      $display("FAIL bp_data_hold: got %0d bad cycles want 0", bad_c);
    end
    checks++;
    if (bad_r !== 0) begin
      errors++;
      $display("FAIL bp_ready_low: got %0d bad cycles want 0", bad_r);
    end
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_idle: got busy=%b want 0", busy);
    end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid === 1'b1) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL bp_single_resp: got %0d extra resp cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int stale;
    logic [4:0] cnt;
    logic [1:0] rid;
    int lat;
    req_data[47:32] = 16'hFFFF;
    req_valid = 4'b0100;
    #1;
    n = 0;
    while (req_ready[2] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL rm_grant: got ready=%b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL rm_ready_in_rst: got %b want 0000", req_ready);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_count !== 5'd0 ||
        resp_id !== 2'd0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL rm_outputs: got v=%b b=%b c=%0d id=%0d want all 0",
               resp_valid, busy, resp_count, resp_id);
    end
    checks++;
    if (dut.r_ptr !== 2'd0) begin
      errors++;
      $display("FAIL rm_ptr: got %0d want 0", dut.r_ptr);
    end
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid === 1'b1) stale++;
      step();
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL rm_stale: got %0d resp cycles want 0", stale);
    end
    do_txn(0, 16'hA5A5, cnt, rid, lat);
    checks++;
    if (cnt !== 5'd8 || rid !== 2'd0 || lat !== 5) begin
      errors++;
      $display("FAIL rm_fresh: got count=%0d id=%0d lat=%0d want 8 0 5",
               cnt, rid, lat);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_values();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
